// File: rtl/mii_pkg.sv
// Shared types and constants for the MII frame checker: FSM states, control codes, error bit indices.
package mii_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    localparam int          LANES          = 8;
    localparam logic [7:0]  IDLE_CODE      = 8'h07;
    localparam logic [7:0]  START_CODE     = 8'hFB;
    localparam logic [7:0]  DATA_CODE      = 8'hAA;
    localparam logic [7:0]  TERMINATE_CODE = 8'hFD;

    localparam int ERR_SHORT     = 0;
    localparam int ERR_LONG      = 1;
    localparam int ERR_CTRL      = 2;
    localparam int ERR_TERM_IDLE = 3;
    localparam int ERR_PATTERN   = 4;
    localparam int ERR_W         = 5;

endpackage

// File: rtl/mii_term_lane_finder.sv
// Combinational decode of one 64-bit word: locates the lowest terminate lane and qualifies
// the control lanes below it and the idle tail above it.
module mii_term_lane_finder
    import mii_pkg::*;
#(
    parameter logic [7:0] IDLE_CODE      = mii_pkg::IDLE_CODE,
    parameter logic [7:0] TERMINATE_CODE = mii_pkg::TERMINATE_CODE
) (
    input  logic [63:0] i_data,
    input  logic [7:0]  i_ctrl,
    output logic        o_term_found,
    output logic [2:0]  o_term_lane,
    output logic [7:0]  o_ctrl_below_mask,
    output logic        o_idle_above_ok
);

    always_comb begin
        o_term_found      = 1'b0;
        o_term_lane       = 3'd0;
        o_ctrl_below_mask = 8'd0;
        o_idle_above_ok   = 1'b0;
        // Scan downwards so the lowest matching lane wins.
        for (int k = LANES - 1; k >= 0; k--) begin
            if (i_ctrl[k] && (i_data[8*k +: 8] == TERMINATE_CODE)) begin
                o_term_found = 1'b1;
                o_term_lane  = 3'(k);
            end
        end
        o_idle_above_ok = o_term_found;
        for (int k = 0; k < LANES; k++) begin
            if (k < int'(o_term_lane)) begin
                o_ctrl_below_mask[k] = i_ctrl[k];
            end else if (k > int'(o_term_lane)) begin
                if (!(i_ctrl[k] && (i_data[8*k +: 8] == IDLE_CODE)))
                    o_idle_above_ok = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mii_frame_checker.sv
// Receive-side MII frame checker: frame delineation, length bounds, control placement, totals.
// Optional payload pattern check enabled by defining MII_CHECKER_PATTERN_CHECK_EN.
module mii_frame_checker
    import mii_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned CTRL_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned MIN_LEN        = 46,
    parameter int unsigned MAX_LEN        = 1500,
    parameter logic [7:0]  IDLE_CODE      = mii_pkg::IDLE_CODE,
    parameter logic [7:0]  START_CODE     = mii_pkg::START_CODE,
`ifdef MII_CHECKER_PATTERN_CHECK_EN
    parameter logic [7:0]  DATA_CODE      = mii_pkg::DATA_CODE,
`endif
    parameter logic [7:0]  TERMINATE_CODE = mii_pkg::TERMINATE_CODE
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
    output logic                  o_frame_done,
    output logic [15:0]           o_frame_len,
    output logic [ERR_W-1:0]      o_err_flags,
    output logic                  o_idle_err,
    output logic [31:0]           o_frame_cnt,
    output logic [31:0]           o_err_cnt
);

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {13'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    state_t             r_state;
    logic [15:0]        r_len;
    logic [ERR_W-1:0]   r_flags;
    logic               r_frame_done;
    logic [15:0]        r_frame_len;
    logic [ERR_W-1:0]   r_err_flags;
    logic               r_idle_err;
    logic [31:0]        r_frame_cnt;
    logic [31:0]        r_err_cnt;

    logic               w_term_found;
    logic [2:0]         w_term_lane;
    logic [7:0]         w_ctrl_below;
    logic               w_idle_above_ok;
    logic [7:0]         w_below_t;
    logic [7:0]         w_lane_bad;
    logic [3:0]         w_data_lanes;
    logic               w_is_start;
    logic               w_all_idle;
    logic [3:0]         w_add;
    logic [ERR_W-1:0]   w_new_flags;
    logic               w_close;
    logic               w_reopen;
    logic [15:0]        w_sum_len;
    logic [ERR_W-1:0]   w_sum_flags;
    logic [ERR_W-1:0]   w_final_flags;

    mii_term_lane_finder #(
        .IDLE_CODE      (IDLE_CODE),
        .TERMINATE_CODE (TERMINATE_CODE)
    ) u_finder (
        .i_data            (i_rx_data),
        .i_ctrl            (i_rx_ctrl),
        .o_term_found      (w_term_found),
        .o_term_lane       (w_term_lane),
        .o_ctrl_below_mask (w_ctrl_below),
        .o_idle_above_ok   (w_idle_above_ok)
    );

    assign w_is_start = (i_rx_ctrl == 8'h01) && (i_rx_data[7:0] == START_CODE);
    assign w_all_idle = (i_rx_ctrl == 8'hFF) && (i_rx_data == {8{IDLE_CODE}});
    assign w_below_t  = (8'd1 << w_term_lane) - 8'd1;

`ifdef MII_CHECKER_PATTERN_CHECK_EN
    always_comb begin
        w_lane_bad = 8'd0;
        for (int k = 0; k < LANES; k++)
            w_lane_bad[k] = (i_rx_data[8*k +: 8] != DATA_CODE);
    end
`else
    assign w_lane_bad = 8'd0;
`endif

    always_comb begin
        w_data_lanes = 4'd0;
        for (int k = 0; k < LANES; k++)
            w_data_lanes = w_data_lanes + {3'd0, ~i_rx_ctrl[k]};
    end

    // Per-word contribution while inside a frame.
    always_comb begin
        w_add       = 4'd0;
        w_new_flags = '0;
        w_close     = 1'b0;
        w_reopen    = 1'b0;
        if (i_rx_ctrl == 8'd0) begin
            w_add                    = 4'd8;
            w_new_flags[ERR_PATTERN] = |w_lane_bad;
        end else if (w_term_found) begin
            w_add                      = {1'b0, w_term_lane};
            w_new_flags[ERR_CTRL]      = |w_ctrl_below;
            w_new_flags[ERR_TERM_IDLE] = !w_idle_above_ok;
            w_new_flags[ERR_PATTERN]   = |(w_lane_bad & w_below_t);
            w_close                    = 1'b1;
        end else if (w_is_start) begin
            w_new_flags[ERR_CTRL] = 1'b1;
            w_close               = 1'b1;
            w_reopen              = 1'b1;
        end else if (w_all_idle) begin
            w_new_flags[ERR_CTRL] = 1'b1;
            w_close               = 1'b1;
        end else begin
            w_add                    = w_data_lanes;
            w_new_flags[ERR_CTRL]    = 1'b1;
            w_new_flags[ERR_PATTERN] = |(w_lane_bad & ~i_rx_ctrl);
        end
    end

    always_comb begin
        w_sum_len                = sat_add16(r_len, w_add);
        w_sum_flags              = r_flags | w_new_flags;
        w_final_flags            = w_sum_flags;
        w_final_flags[ERR_SHORT] = ({16'd0, w_sum_len} < 32'(MIN_LEN));
        w_final_flags[ERR_LONG]  = ({16'd0, w_sum_len} > 32'(MAX_LEN));
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_len        <= 16'd0;
            r_flags      <= '0;
            r_frame_done <= 1'b0;
            r_frame_len  <= 16'd0;
            r_err_flags  <= '0;
            r_idle_err   <= 1'b0;
            r_frame_cnt  <= 32'd0;
            r_err_cnt    <= 32'd0;
        end else begin
            r_frame_done <= 1'b0;
            r_idle_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_is_start) begin
                        r_state <= ST_DATA;
                        r_len   <= 16'd0;
                        r_flags <= '0;
                    end else if (!w_all_idle) begin
                        r_idle_err <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_close) begin
                        r_frame_done <= 1'b1;
                        r_frame_len  <= w_sum_len;
                        r_err_flags  <= w_final_flags;
                        r_frame_cnt  <= r_frame_cnt + 32'd1;
                        if (|w_final_flags)
                            r_err_cnt <= r_err_cnt + 32'd1;
                        r_len   <= 16'd0;
                        r_flags <= '0;
                        r_state <= w_reopen ? ST_DATA : ST_IDLE;
                    end else begin
                        r_len   <= w_sum_len;
                        r_flags <= w_sum_flags;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_frame_done = r_frame_done;
    assign o_frame_len  = r_frame_len;
    assign o_err_flags  = r_err_flags;
    assign o_idle_err   = r_idle_err;
    assign o_frame_cnt  = r_frame_cnt;
    assign o_err_cnt    = r_err_cnt;

endmodule
